ms_timer: RTL and testbench

Programmable countdown timer clocked by the time-unit enables from the time-unit generator. It counts either microsecond or millisecond ticks from a loaded value down to zero and pulses `done` on expiry. It is the shared timeout and interval primitive for receiver control logic: sample windows, settle delays, and display refresh. An optional auto-reload mode turns it into a periodic interval source.

---
 rtl/ms_timer.sv | 95 +++++++++
 tb/tb_ms_timer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ms_timer.sv
// Programmable countdown timer driven by microsecond/millisecond tick enables.
// Define MS_TIMER_PERIODIC_EN to build the auto-reload (periodic) mode.
module ms_timer #(
    parameter int CNT_DW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              us_en,
    input  logic              ms_en,
    input  logic              start,
    input  logic              abort,
    input  logic              tick_sel,
    input  logic              periodic,
    input  logic [CNT_DW-1:0] load_val,
    output logic              busy,
    output logic              done,
    output logic [CNT_DW-1:0] remaining
);

    localparam logic [0:0]        ST_IDLE = 1'b0;
    localparam logic [0:0]        ST_RUN  = 1'b1;
    localparam logic [CNT_DW-1:0] CNT_ONE = {{(CNT_DW-1){1'b0}}, 1'b1};

    logic [0:0]        state;
    logic              tick_sel_q;
    logic [CNT_DW-1:0] load_q;
    logic              reload;
    logic              tick;

    // The tick source is frozen at start so a later change of tick_sel cannot
    // switch units mid-count.
    assign tick = tick_sel_q ? us_en : ms_en;
    assign busy = (state == ST_RUN);

`ifdef MS_TIMER_PERIODIC_EN
    logic periodic_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            periodic_q <= 1'b0;
        end else if (!abort && start && (load_val != '0)) begin
            periodic_q <= periodic;
        end
    end

    assign reload = periodic_q;
`else
    logic [CNT_DW:0] unused_cfg;

    assign unused_cfg = {periodic, load_q};
    assign reload     = 1'b0;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, avoiding order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            done       <= 1'b0;
            tick_sel_q <= 1'b0;
            load_q     <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                remaining <= '0;
            end else if (start) begin
                if (load_val != '0) begin
                    tick_sel_q <= tick_sel;
                    load_q     <= load_val;
                    remaining  <= load_val;
                    state      <= ST_RUN;
                end else begin
                    remaining <= '0;
                    state     <= ST_IDLE;
                    done      <= 1'b1;
                end
            end else if ((state == ST_RUN) && tick) begin
                if (remaining == CNT_ONE) begin
                    done <= 1'b1;
                    if (reload) begin
                        remaining <= load_q;
                    end else begin
                        remaining <= '0;
                        state     <= ST_IDLE;
                    end
                end else if (remaining != '0) begin
                    remaining <= remaining - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ms_timer.sv
// Self-checking bench for ms_timer: a table of per-cycle vectors plus
// hand-written sequences for reset and periodic mode.
module tb_ms_timer;

    localparam int DW = 16;
`ifdef MS_TIMER_PERIODIC_EN
    localparam bit PER = 1'b1;
`else
    localparam bit PER = 1'b0;
`endif

    typedef struct {
        logic          start;
        logic          abort;
        logic          tick_sel;
        logic          periodic;
        logic          us;
        logic          ms;
        logic [DW-1:0] ld;
        logic          e_busy;
        logic          e_done;
        logic [DW-1:0] e_rem;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          us_en, ms_en, start, abort, tick_sel, periodic;
    logic [DW-1:0] load_val;
    logic          busy, done;
    logic [DW-1:0] remaining;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    ms_timer #(.CNT_DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .us_en    (us_en),
        .ms_en    (ms_en),
        .start    (start),
        .abort    (abort),
        .tick_sel (tick_sel),
        .periodic (periodic),
        .load_val (load_val),
        .busy     (busy),
        .done     (done),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic eb, input logic ed, input logic [DW-1:0] er);
        n_tests++;
        if (busy !== eb || done !== ed || remaining !== er) begin
            n_fail++;
            $display("FAIL %s: got busy=%b done=%b rem=%0d, expected busy=%b done=%b rem=%0d",
                     name, busy, done, remaining, eb, ed, er);
        end
    endtask

    task automatic add(input logic s, input logic a, input logic ts, input logic p,
                       input logic u, input logic m, input logic [DW-1:0] ld,
                       input logic eb, input logic ed, input logic [DW-1:0] er);
        vec_t v;
        v = '{s, a, ts, p, u, m, ld, eb, ed, er};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic s, input logic a, input logic ts, input logic p,
                         input logic u, input logic m, input logic [DW-1:0] ld);
        start = s; abort = a; tick_sel = ts; periodic = p;
        us_en = u; ms_en = m; load_val = ld;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0; us_en = 1'b0; ms_en = 1'b0;
    endtask

    initial begin
        // one-shot ms count of 3; a us tick must not count
        add(1,0,0,0, 0,0, 3,  1,0,3);
        add(0,0,0,0, 0,0, 0,  1,0,3);
        add(0,0,0,0, 0,1, 0,  1,0,2);
        add(0,0,0,0, 0,1, 0,  1,0,1);
        add(0,0,0,0, 1,0, 0,  1,0,1);
        add(0,0,0,0, 0,1, 0,  0,1,0);
        add(0,0,0,0, 0,0, 0,  0,0,0);
        // us source of 5 with interleaved ms; tick_sel input dropped after start
        add(1,0,1,0, 0,0, 5,  1,0,5);
        add(0,0,0,0, 0,1, 0,  1,0,5);
        add(0,0,0,0, 1,0, 0,  1,0,4);
        add(0,0,0,0, 1,0, 0,  1,0,3);
        add(0,0,0,0, 0,1, 0,  1,0,3);
        add(0,0,0,0, 1,0, 0,  1,0,2);
        add(0,0,0,0, 1,0, 0,  1,0,1);
        add(0,0,0,0, 0,1, 0,  1,0,1);
        add(0,0,0,0, 1,0, 0,  0,1,0);
        add(0,0,0,0, 0,0, 0,  0,0,0);
        // zero load: done next cycle, busy never rises
        add(1,0,0,0, 0,0, 0,  0,1,0);
        add(0,0,0,0, 0,0, 0,  0,0,0);
        // start colliding with a tick: the tick is ignored
        add(1,0,0,0, 0,1, 2,  1,0,2);
        add(0,0,0,0, 0,1, 0,  1,0,1);
        add(0,0,0,0, 0,1, 0,  0,1,0);
        add(0,0,0,0, 0,0, 0,  0,0,0);
        // abort beats an expiring tick, then abort beats start
        add(1,0,0,0, 0,0, 1,  1,0,1);
        add(0,1,0,0, 0,1, 0,  0,0,0);
        add(0,0,0,0, 0,0, 0,  0,0,0);
        add(1,1,0,0, 0,0, 7,  0,0,0);
        add(0,0,0,0, 0,1, 0,  0,0,0);
        // restart from 4 down to 10
        add(1,0,0,0, 0,0, 4,  1,0,4);
        add(0,0,0,0, 0,0, 0,  1,0,4);
        add(1,0,0,0, 0,0, 10, 1,0,10);
        for (int k = 9; k >= 1; k--)
            add(0,0,0,0, 0,1, 0,  1,0,DW'(k));
        add(0,0,0,0, 0,1, 0,  0,1,0);
        add(0,0,0,0, 0,0, 0,  0,0,0);

        rst = 1'b1;
        start = 1'b0; abort = 1'b0; tick_sel = 1'b0; periodic = 1'b0;
        us_en = 1'b0; ms_en = 1'b0; load_val = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 1'b0, 1'b0, '0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].abort, vecs[i].tick_sel, vecs[i].periodic,
                  vecs[i].us, vecs[i].ms, vecs[i].ld);
            check($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_done, vecs[i].e_rem);
        end

        // periodic load 2: reloads when built with the feature, one-shot otherwise
        drive(1,0,0,1, 0,0, 2);
        check("per_start", 1'b1, 1'b0, 16'd2);
        drive(0,0,0,0, 0,1, 0);
        check("per_t1", 1'b1, 1'b0, 16'd1);
        drive(0,0,0,0, 0,1, 0);
        check("per_exp1", PER, 1'b1, PER ? 16'd2 : 16'd0);
        drive(0,0,0,0, 0,1, 0);
        check("per_t3", PER, 1'b0, PER ? 16'd1 : 16'd0);
        drive(0,0,0,0, 0,1, 0);
        check("per_exp2", PER, PER, PER ? 16'd2 : 16'd0);
        drive(0,1,0,0, 0,0, 0);
        check("per_abort", 1'b0, 1'b0, 16'd0);
        drive(0,0,0,0, 0,1, 0);
        check("per_idle", 1'b0, 1'b0, 16'd0);

        // asynchronous reset mid-run
        drive(1,0,1,0, 0,0, 9);
        check("pre_rst", 1'b1, 1'b0, 16'd9);
        #2 rst = 1'b1;
        #1;
        check("async_rst", 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0,0,0,0, 1,0, 0);
        check("post_rst", 1'b0, 1'b0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
